// File: rtl/mux4_rr_sel_ctrl_if.sv
// ---------------------------------------------------------------------------
// mux4_rr_sel_ctrl_if
// Bundle of the signals between the round-robin selection controller, its
// four requesters, the downstream 4:1 enable mux and the output consumer.
//
// Signals:
//   req       : level request per source, bit i = mux input i (a,b,c,d)
//   mux_out   : data returned from the 4:1 mux output
//   sel       : mux select (registered in the controller)
//   enable    : mux enable (registered in the controller)
//   gnt       : one-hot grant/ack pulse, one cycle wide
//   out_data  : captured word
//   out_valid : out_data holds a word not yet accepted
//   out_ready : consumer accepts on a clock edge where out_valid && out_ready
//
// Modports:
//   master : the controller side (drives sel/enable/gnt/out_*)
//   slave  : the environment side (requesters, mux, consumer)
// ---------------------------------------------------------------------------
interface mux4_rr_sel_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       req;
    logic [WIDTH-1:0] mux_out;
    logic [1:0]       sel;
    logic             enable;
    logic [3:0]       gnt;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  req,
        input  mux_out,
        input  out_ready,
        output sel,
        output enable,
        output gnt,
        output out_data,
        output out_valid
    );

    modport slave (
        output req,
        output mux_out,
        output out_ready,
        input  sel,
        input  enable,
        input  gnt,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/mux4_rr_sel_ctrl.sv
// ---------------------------------------------------------------------------
// mux4_rr_sel_ctrl
// Round-robin selection controller placed in front of a 4:1 enable mux.
// Picks one requesting source in rotating order, steers the mux to it, waits
// one cycle for the mux to settle, captures the mux output into a registered
// valid/ready stage and pulses the source's grant.
//
// Ports:
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   bus         : mux4_rr_sel_ctrl_if.master (req, mux_out, sel, enable,
//                 gnt, out_data, out_valid, out_ready)
//   o_dbg_state : current FSM state (0=IDLE, 1=SELECT, 2=HOLD)
//
// Handshake: out_valid rises with the captured word and stays high, with
// out_data stable, until an edge where out_ready is also high; that edge is
// the transfer. out_valid only falls on a transfer or on reset.
// ---------------------------------------------------------------------------
module mux4_rr_sel_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mux4_rr_sel_ctrl_if.master     bus,
    output logic [1:0]             o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_last_ptr;
    logic [1:0]       w_last_ptr_nxt;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_nxt;
    logic             r_enable;
    logic             w_enable_nxt;
    logic [3:0]       r_gnt;
    logic [3:0]       w_gnt_nxt;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] w_out_data_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;

    logic [1:0]       w_winner;
    logic             w_found;
    logic [1:0]       w_idx;

    // Rotating priority scan: last_ptr+1 first, last_ptr itself last.
    always_comb begin
        w_winner = r_last_ptr;
        w_found  = 1'b0;
        w_idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last_ptr + k[1:0];
            if (!w_found && bus.req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_last_ptr_nxt  = r_last_ptr;
        w_sel_nxt       = r_sel;
        w_enable_nxt    = r_enable;
        w_gnt_nxt       = 4'b0000;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        case (r_state)
            IDLE: begin
                w_enable_nxt = 1'b0;
                if (|bus.req) begin
                    w_sel_nxt    = w_winner;
                    w_enable_nxt = 1'b1;
                    w_state_nxt  = SELECT;
                end
            end
            SELECT: begin
                // Mux has had a full cycle on the new sel; capture and ack.
                w_out_data_nxt  = bus.mux_out;
                w_out_valid_nxt = 1'b1;
                w_gnt_nxt       = 4'b0001 << r_sel;
                w_last_ptr_nxt  = r_sel;
                w_state_nxt     = HOLD;
            end
            HOLD: begin
                // last_ptr already equals sel here, so the scan starts after
                // the channel just served.
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (|bus.req) begin
                        w_sel_nxt    = w_winner;
                        w_enable_nxt = 1'b1;
                        w_state_nxt  = SELECT;
                    end else begin
                        w_enable_nxt = 1'b0;
                        w_state_nxt  = IDLE;
                    end
                end
            end
            default: begin
                w_enable_nxt    = 1'b0;
                w_out_valid_nxt = 1'b0;
                w_state_nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last_ptr  <= 2'd3;
            r_sel       <= 2'd0;
            r_enable    <= 1'b0;
            r_gnt       <= 4'b0000;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_ptr  <= w_last_ptr_nxt;
            r_sel       <= w_sel_nxt;
            r_enable    <= w_enable_nxt;
            r_gnt       <= w_gnt_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign bus.sel       = r_sel;
    assign bus.enable    = r_enable;
    assign bus.gnt       = r_gnt;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mux4_rr_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_sel_ctrl
// Directed bench for mux4_rr_sel_ctrl. A behavioural 4:1 enable mux with
// fixed inputs a=0001, b=0010, c=0100, d=1000 feeds mux_out. Inputs change
// 1 ns after a rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_mux4_rr_sel_ctrl;

    localparam int WIDTH = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         n_tests;
    int         n_fail;
    logic [3:0] mux_in [4];
    logic [3:0] exp_gnt;

    mux4_rr_sel_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mux4_rr_sel_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.master),
        .o_dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mux model: zero when disabled, otherwise the selected fixed input.
    assign bus.mux_out = bus.enable ? mux_in[bus.sel] : 4'b0000;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        mux_in[0]     = 4'b0001;
        mux_in[1]     = 4'b0010;
        mux_in[2]     = 4'b0100;
        mux_in[3]     = 4'b1000;
        bus.req       = 4'b0000;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;

        // Reset / idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            check("idle_sel", 32'(bus.sel), 32'd0);
            check("idle_enable", 32'(bus.enable), 32'd0);
            check("idle_gnt", 32'(bus.gnt), 32'd0);
            check("idle_valid", 32'(bus.out_valid), 32'd0);
            tick();
        end

        // Single request on channel c
        bus.req       = 4'b0100;
        bus.out_ready = 1'b1;
        tick();
        check("single_sel", 32'(bus.sel), 32'd2);
        check("single_enable", 32'(bus.enable), 32'd1);
        check("single_state_sel", 32'(dbg_state), 32'd1);
        check("single_valid_early", 32'(bus.out_valid), 32'd0);
        tick();
        check("single_data", 32'(bus.out_data), 32'h4);
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_gnt", 32'(bus.gnt), 32'h4);
        check("single_state_hold", 32'(dbg_state), 32'd2);
        bus.req = 4'b0000;
        tick();
        check("single_gnt_off", 32'(bus.gnt), 32'd0);
        check("single_valid_off", 32'(bus.out_valid), 32'd0);
        check("single_enable_off", 32'(bus.enable), 32'd0);
        check("single_state_idle", 32'(dbg_state), 32'd0);

        // Round-robin from a fresh reset: ch0 first
        do_reset();
        bus.req       = 4'b1111;
        bus.out_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            exp_gnt = mux_in[g % 4];
            tick();
            check("rr_sel", 32'(bus.sel), 32'(g % 4));
            check("rr_gnt_gap", 32'(bus.gnt), 32'd0);
            check("rr_valid_gap", 32'(bus.out_valid), 32'd0);
            tick();
            check("rr_gnt", 32'(bus.gnt), 32'(exp_gnt));
            check("rr_data", 32'(bus.out_data), 32'(exp_gnt));
            check("rr_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.req = 4'b0000;
        tick();
        check("rr_end_enable", 32'(bus.enable), 32'd0);
        check("rr_end_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure on channel b (last grant was ch0)
        bus.req       = 4'b0010;
        bus.out_ready = 1'b0;
        tick();
        check("bp_sel", 32'(bus.sel), 32'd1);
        tick();
        check("bp_gnt", 32'(bus.gnt), 32'h2);
        check("bp_valid", 32'(bus.out_valid), 32'd1);
        bus.req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_data", 32'(bus.out_data), 32'h2);
            check("bp_hold_gnt", 32'(bus.gnt), 32'd0);
            check("bp_hold_enable", 32'(bus.enable), 32'd1);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_accept_valid", 32'(bus.out_valid), 32'd0);
        check("bp_accept_enable", 32'(bus.enable), 32'd0);
        check("bp_accept_gnt", 32'(bus.gnt), 32'd0);

        // Fairness: last grant ch1, req=0011 -> ch0 before ch1
        bus.req = 4'b0011;
        tick();
        check("fair_sel0", 32'(bus.sel), 32'd0);
        tick();
        check("fair_gnt0", 32'(bus.gnt), 32'h1);
        // ch0 drops; ch1 and ch3 now requesting, ch1 comes next after ch0
        bus.req = 4'b1010;
        tick();
        check("fair_sel1", 32'(bus.sel), 32'd1);
        tick();
        check("fair_gnt1", 32'(bus.gnt), 32'h2);
        // ch1 keeps requesting but rotation moves on to ch3
        tick();
        check("fair_sel3", 32'(bus.sel), 32'd3);
        tick();
        check("fair_gnt3", 32'(bus.gnt), 32'h8);
        check("fair_data3", 32'(bus.out_data), 32'h8);
        bus.req = 4'b0000;
        tick();
        check("fair_end_enable", 32'(bus.enable), 32'd0);

        // Mid-transfer req drop on channel d
        bus.req       = 4'b1000;
        bus.out_ready = 1'b0;
        tick();
        check("drop_sel", 32'(bus.sel), 32'd3);
        bus.req = 4'b0000;
        tick();
        check("drop_gnt", 32'(bus.gnt), 32'h8);
        check("drop_data", 32'(bus.out_data), 32'h8);
        repeat (3) tick();
        check("drop_hold_valid", 32'(bus.out_valid), 32'd1);
        check("drop_hold_data", 32'(bus.out_data), 32'h8);
        bus.out_ready = 1'b1;
        tick();
        check("drop_accept_valid", 32'(bus.out_valid), 32'd0);
        check("drop_accept_enable", 32'(bus.enable), 32'd0);
        check("drop_state_idle", 32'(dbg_state), 32'd0);

        // Asynchronous reset while holding a word
        bus.req       = 4'b0001;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("ares_pre_valid", 32'(bus.out_valid), 32'd1);
        bus.req = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check("ares_valid", 32'(bus.out_valid), 32'd0);
        check("ares_enable", 32'(bus.enable), 32'd0);
        check("ares_data", 32'(bus.out_data), 32'd0);
        check("ares_sel", 32'(bus.sel), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ares_after_gnt", 32'(bus.gnt), 32'd0);
            check("ares_after_valid", 32'(bus.out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
